// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32I load/store controller on a word-addressed synchronous RAM port
// Ports: clk, rst_n (async active-low); req_valid/req_ready handshake with req_we, req_funct3,
//        req_addr (byte address), req_wdata; resp_valid strobe with resp_rdata, resp_err;
//        RAM side mem_addr (word index), mem_rw (0 = write, 1 = read), mem_wdata, mem_rdata
//        (registered, valid the cycle after a read cycle).
module data_mem_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic we_q;
  logic [2:0] f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] wword, ld_val, st_word;
  logic [15:0] rhalf;
  logic [7:0] rbyte;
  logic acc, req_err;
  // byte-address bits above the RAM window wrap and are deliberately dropped
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign mem_rw = state != WRITE;
  assign mem_addr = addr_q[ADDR_W+1:2];
  assign mem_wdata = wword;
  always_comb begin
    acc = state == IDLE && req_valid;
    req_err = (req_we ? req_funct3 > 3'd2 : req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11)
           || (req_funct3[1:0] == 2'b01 && req_addr[0])
           || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    rbyte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    rhalf = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    // funct3[2] marks the unsigned variants, so it suppresses sign extension
    ld_val = f3_q[1] ? mem_rdata
           : f3_q[0] ? {{16{rhalf[15] & ~f3_q[2]}}, rhalf}
           : {{24{rbyte[7] & ~f3_q[2]}}, rbyte};
    st_word = mem_rdata;
    if (f3_q[0]) st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    state_nx = state;
    case (state)
      IDLE:    state_nx = !acc ? IDLE : req_err ? RESP : (req_we && req_funct3 == 3'd2) ? WRITE : READ;
      READ:    state_nx = WAIT;
      WAIT:    state_nx = we_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      f3_q <= 3'd0;
      addr_q <= '0;
      wdata_q <= 16'h0;
      wword <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err <= 1'b0;
    end else begin
      if (acc) begin
        we_q <= req_we;
        f3_q <= req_funct3;
        addr_q <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata[15:0];
        wword <= req_wdata;
      end
      if (state == WAIT && we_q) wword <= st_word;
      // response fields change only when entering RESP and hold afterwards
      if (state_nx == RESP && state != RESP) begin
        resp_rdata <= (state == WAIT && !we_q) ? ld_val : 32'h0;
        resp_err <= state == IDLE;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: self-checking bench for data_mem_ctrl with a RAM fixture and a byte-level reference model
module tb_data_mem_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, mem_rdata = 32'h0;
  logic req_ready, resp_valid, resp_err, mem_rw;
  logic [31:0] resp_rdata, mem_wdata;
  logic [4:0] mem_addr;
  logic [31:0] ram [32] = '{default: 32'h0};
  logic [31:0] ref_mem [32] = '{default: 32'h0};
  int checks = 0, errors = 0, wr_cnt = 0, resp_cnt = 0;
  logic [4:0] last_wa = 5'h0;
  logic [31:0] last_wd = 32'h0;
  typedef struct packed {
    logic we; logic [2:0] f3; logic [31:0] a, wd, rd; logic er; logic [1:0] lat; logic [31:0] mw;
  } vec_t;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr), .mem_rw(mem_rw),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (!mem_rw) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
    if (resp_valid) resp_cnt++;
  end

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a, wd,
                                output logic [31:0] rd, output logic er, output int lat);
    int sz, lane;
    logic [31:0] w, v;
    sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    er = f3[1:0] == 2'd3 || (f3[2] && (we || f3[1:0] == 2'd2)) || ((a & (sz - 1)) != 0);
    rd = 32'h0;
    lat = 0;
    if (er) return;
    lane = int'(a[1:0]);
    w = ref_mem[a[6:2]];
    if (we) begin
      for (int i = 0; i < sz; i++) w[8*(lane+i) +: 8] = wd[8*i +: 8];
      ref_mem[a[6:2]] = w;
      lat = sz == 4 ? 1 : 3;
    end else begin
      v = w >> (8 * lane);
      if (sz < 4) begin
        v = v & ((32'd1 << (8 * sz)) - 32'd1);
        if (!f3[2] && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
      end
      rd = v;
      lat = 2;
    end
  endfunction

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a, wd,
                         output logic [31:0] rd, output logic er, output int lat, output int nw);
    int w0;
    w0 = wr_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err; nw = wr_cnt - w0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'h0, 32'h0})
      begin errors++; $display("FAIL reset_in outputs got %h", {req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'h0, 32'h0})
      begin errors++; $display("FAIL reset_out outputs got %h", {req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata}); end
  endtask

  task automatic test_store_load;
    vec_t t [6];
    logic [31:0] rd, m_rd; logic er, m_er; int lat, nw, m_lat;
    t = '{{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2'd1, 32'hDEADBEEF},
          {1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2'd2, 32'h0},
          {1'b0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2'd2, 32'h0},
          {1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2'd2, 32'h0},
          {1'b0, 3'd5, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 2'd2, 32'h0},
          {1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2'd2, 32'h0}};
    for (int i = 0; i < 6; i++) begin
      model(t[i].we, t[i].f3, t[i].a, t[i].wd, m_rd, m_er, m_lat);
      run_req(t[i].we, t[i].f3, t[i].a, t[i].wd, rd, er, lat, nw);
      checks++; if (rd !== t[i].rd) begin errors++; $display("FAIL store_load[%0d] rdata got %h exp %h", i, rd, t[i].rd); end
      checks++; if (er !== t[i].er) begin errors++; $display("FAIL store_load[%0d] err got %b exp %b", i, er, t[i].er); end
      checks++; if (lat !== int'(t[i].lat)) begin errors++; $display("FAIL store_load[%0d] latency got %0d exp %0d", i, lat, t[i].lat); end
      checks++; if (nw !== int'(t[i].we)) begin errors++; $display("FAIL store_load[%0d] writes got %0d exp %0d", i, nw, t[i].we); end
      if (t[i].we) begin
        checks++;
        if ({last_wa, last_wd} !== {t[i].a[6:2], t[i].mw}) begin errors++; $display("FAIL store_load[%0d] write got %h:%h exp %h:%h", i, last_wa, last_wd, t[i].a[6:2], t[i].mw); end
      end
    end
  endtask

  task automatic test_subword;
    vec_t t [3];
    logic [31:0] rd, m_rd; logic er, m_er; int lat, nw, m_lat;
    t = '{{1'b1, 3'd0, 32'h11, 32'h000000AA, 32'h0,        1'b0, 2'd3, 32'hDEADAAEF},
          {1'b1, 3'd1, 32'h12, 32'h00001234, 32'h0,        1'b0, 2'd3, 32'h1234AAEF},
          {1'b0, 3'd2, 32'h10, 32'h0,        32'h1234AAEF, 1'b0, 2'd2, 32'h0}};
    for (int i = 0; i < 3; i++) begin
      model(t[i].we, t[i].f3, t[i].a, t[i].wd, m_rd, m_er, m_lat);
      run_req(t[i].we, t[i].f3, t[i].a, t[i].wd, rd, er, lat, nw);
      checks++; if (rd !== t[i].rd) begin errors++; $display("FAIL subword[%0d] rdata got %h exp %h", i, rd, t[i].rd); end
      checks++; if (er !== t[i].er) begin errors++; $display("FAIL subword[%0d] err got %b exp %b", i, er, t[i].er); end
      checks++; if (lat !== int'(t[i].lat)) begin errors++; $display("FAIL subword[%0d] latency got %0d exp %0d", i, lat, t[i].lat); end
      checks++; if (nw !== int'(t[i].we)) begin errors++; $display("FAIL subword[%0d] writes got %0d exp %0d", i, nw, t[i].we); end
      if (t[i].we) begin
        checks++;
        if ({last_wa, last_wd} !== {t[i].a[6:2], t[i].mw}) begin errors++; $display("FAIL subword[%0d] write got %h:%h exp %h:%h", i, last_wa, last_wd, t[i].a[6:2], t[i].mw); end
      end
    end
  endtask

  task automatic test_errors;
    vec_t t [3];
    logic [31:0] rd, m_rd; logic er, m_er; int lat, nw, m_lat;
    t = '{{1'b0, 3'd2, 32'h02, 32'h0,      32'h0, 1'b1, 2'd0, 32'h0},
          {1'b1, 3'd1, 32'h11, 32'h5555,   32'h0, 1'b1, 2'd0, 32'h0},
          {1'b0, 3'd3, 32'h10, 32'h0,      32'h0, 1'b1, 2'd0, 32'h0}};
    for (int i = 0; i < 3; i++) begin
      model(t[i].we, t[i].f3, t[i].a, t[i].wd, m_rd, m_er, m_lat);
      run_req(t[i].we, t[i].f3, t[i].a, t[i].wd, rd, er, lat, nw);
      checks++; if ({rd, er} !== {t[i].rd, t[i].er}) begin errors++; $display("FAIL errors[%0d] rdata/err got %h/%b exp %h/%b", i, rd, er, t[i].rd, t[i].er); end
      checks++; if (lat !== 0) begin errors++; $display("FAIL errors[%0d] latency got %0d exp 0", i, lat); end
      checks++; if (nw !== 0) begin errors++; $display("FAIL errors[%0d] writes got %0d exp 0", i, nw); end
    end
    model(1'b0, 3'd2, 32'h0, 32'h0, m_rd, m_er, m_lat);
    run_req(1'b0, 3'd2, 32'h0, 32'h0, rd, er, lat, nw);
    checks++; if ({rd, er} !== {m_rd, m_er}) begin errors++; $display("FAIL errors word0 got %h/%b exp %h/%b", rd, er, m_rd, m_er); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ad [3], wdv [3], m_rd; logic m_er, bad; int m_lat, r0, w0, cyc;
    ad = '{32'h40, 32'h44, 32'h7C};
    r0 = resp_cnt; w0 = wr_cnt;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wdv[k] = $urandom;
      req_we = 1'b1; req_funct3 = 3'd2; req_addr = ad[k]; req_wdata = wdv[k];
      model(1'b1, 3'd2, ad[k], wdv[k], m_rd, m_er, m_lat);
      @(posedge clk); #1;
      cyc = 0; bad = 1'b0;
      while (!resp_valid && cyc < 8) begin
        bad |= req_ready;
        @(posedge clk); #1;
        cyc++;
      end
      bad |= req_ready;
      checks++; if (bad) begin errors++; $display("FAIL b2b[%0d] req_ready got 1 exp 0 while busy", k); end
      checks++; if (cyc !== m_lat) begin errors++; $display("FAIL b2b[%0d] latency got %0d exp %0d", k, cyc, m_lat); end
      checks++; if ({last_wa, last_wd} !== {ad[k][6:2], wdv[k]}) begin errors++; $display("FAIL b2b[%0d] write got %h:%h exp %h:%h", k, last_wa, last_wd, ad[k][6:2], wdv[k]); end
      if (k == 2) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (wr_cnt - w0 !== 3) begin errors++; $display("FAIL b2b writes got %0d exp 3", wr_cnt - w0); end
    checks++; if (resp_cnt - r0 !== 3) begin errors++; $display("FAIL b2b responses got %0d exp 3", resp_cnt - r0); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (ram[ad[k][6:2]] !== ref_mem[ad[k][6:2]]) begin errors++; $display("FAIL b2b ram[%0d] got %h exp %h", ad[k][6:2], ram[ad[k][6:2]], ref_mem[ad[k][6:2]]); end
    end
  endtask

  task automatic test_random;
    logic we, er, e_er; logic [2:0] f3; logic [31:0] a, wd, rd, e_rd; int lat, nw, e_lat;
    logic [2:0] lf [5];
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom); a = $urandom; wd = $urandom;
      f3 = we ? 3'($urandom_range(2)) : lf[$urandom_range(4)];
      if ($urandom_range(5) == 0) f3 = 3'($urandom);
      if ($urandom_range(3) != 0) a[1:0] = f3[1:0] == 2'd0 ? a[1:0] : f3[1:0] == 2'd1 ? {a[1], 1'b0} : 2'b00;
      model(we, f3, a, wd, e_rd, e_er, e_lat);
      run_req(we, f3, a, wd, rd, er, lat, nw);
      checks++; if ({rd, er} !== {e_rd, e_er}) begin errors++; $display("FAIL rand[%0d] we=%b f3=%0d a=%h rdata/err got %h/%b exp %h/%b", n, we, f3, a, rd, er, e_rd, e_er); end
      checks++; if (lat !== e_lat) begin errors++; $display("FAIL rand[%0d] latency got %0d exp %0d", n, lat, e_lat); end
      checks++; if (nw !== ((we && !e_er) ? 1 : 0)) begin errors++; $display("FAIL rand[%0d] writes got %0d exp %0d", n, nw, (we && !e_er) ? 1 : 0); end
      if (we && !e_er) begin
        checks++;
        if ({last_wa, last_wd} !== {a[6:2], ref_mem[a[6:2]]}) begin errors++; $display("FAIL rand[%0d] write got %h:%h exp %h:%h", n, last_wa, last_wd, a[6:2], ref_mem[a[6:2]]); end
      end
    end
  endtask

  task automatic test_reset_in_write;
    logic [31:0] rd, e_rd; logic er, e_er; int lat, nw, e_lat, r0, w0;
    r0 = resp_cnt; w0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h15; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_rw !== 1'b0) begin errors++; $display("FAIL rst_write mem_rw in write cycle got %b exp 0", mem_rw); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'h0, 32'h0})
      begin errors++; $display("FAIL rst_write outputs got %h", {req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ram[5] !== ref_mem[5]) begin errors++; $display("FAIL rst_write word got %h exp %h", ram[5], ref_mem[5]); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL rst_write writes got %0d exp %0d", wr_cnt, w0); end
    checks++; if (resp_cnt !== r0) begin errors++; $display("FAIL rst_write responses got %0d exp %0d", resp_cnt, r0); end
    model(1'b1, 3'd2, 32'h14, 32'hCAFEF00D, e_rd, e_er, e_lat);
    run_req(1'b1, 3'd2, 32'h14, 32'hCAFEF00D, rd, er, lat, nw);
    checks++; if ({lat, nw, er} !== {e_lat, 32'd1, e_er}) begin errors++; $display("FAIL rst_write next_sw lat/writes/err got %0d/%0d/%b exp %0d/1/%b", lat, nw, er, e_lat, e_er); end
    checks++; if ({last_wa, last_wd} !== {5'd5, 32'hCAFEF00D}) begin errors++; $display("FAIL rst_write next_sw write got %h:%h exp 05:cafef00d", last_wa, last_wd); end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_subword;
    test_errors;
    test_back_to_back;
    test_random;
    test_reset_in_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store access controller: the initiator side of the word-addressed synchronous data RAM port (5-bit word address, `readWrite` 0 = write / 1 = read, registered read data one clock after a read cycle). It sits between the single-cycle core's memory stage and the RAM. It accepts byte-addressed RV32I load/store requests over a valid/ready handshake and performs:
- byte/halfword lane extraction with sign/zero extension;
- read-modify-write for sub-word stores;
- alignment checking;
- one response per request.

## Interface
- `ADDR_W`, 5, RAM word-address width; byte address bits `[ADDR_W+1:2]` select the word, higher bits ignored (wrap).
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept; handshake when both high at a rising edge.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: one-cycle response strobe.
- `resp_rdata` output 32: load result; 0 for stores and errors.
- `resp_err` output 1: misaligned or illegal funct3; valid with `resp_valid`.
- `mem_addr` output `ADDR_W`: RAM word address.
- `mem_rw` output 1: RAM `readWrite` (0 = write, 1 = read).
- `mem_wdata` output 32: RAM write data.
- `mem_rdata` input 32: RAM registered read data.

## Operation
- States: IDLE, READ, WAIT, WRITE, RESP. `req_ready` = 1 only in IDLE.
- IDLE: on handshake, latch `we`, `funct3`, `addr`, `wdata`, then classify the request.
  - Error, next state RESP with err = 1. Any of: illegal funct3 (load 011/110/111; store ≥ 011); halfword access with `addr[0]` = 1; word access with `addr[1:0]` ≠ 0.
  - SW: next state WRITE.
  - Any load, SB, SH: next state READ.
- READ: `mem_rw` = 1, `mem_addr` = latched word index; the RAM captures the word at the end of this cycle. Next state WAIT.
- WAIT: `mem_rdata` is valid.
  - Load: register the extracted value into `resp_rdata`; next state RESP.
  - SB/SH: merge the store lanes into the read word, register the result as the write word; next state WRITE.
- WRITE: `mem_rw` = 0, `mem_addr`, `mem_wdata` = write word (SW: latched wdata). Exactly one write cycle per store. Next state RESP.
- RESP: `resp_valid` = 1 for exactly one cycle; next state IDLE.
- Little-endian lane rules.
  - Byte lane = `addr[1:0]`. Half lane = `addr[1]`.
  - LB/LH: sign-extend. LBU/LHU: zero-extend.
  - SB writes `wdata[7:0]` into the byte lane. SH writes `wdata[15:0]` into the half lane. All other bytes are preserved.
- `mem_*` outputs decode from the state and latched registers only; there is no combinational path from `req_*`.
- `mem_rw` = 1 in every state except WRITE, so no spurious writes occur.
- Error requests never drive `mem_rw` = 0.
- `req_*` inputs are ignored outside the IDLE handshake.

## Timing
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `mem_rw` 1, `mem_addr` 0, `mem_wdata` 0, all latched request registers 0.
- Latency, with the accepting edge as edge 0; `resp_valid` is high in the cycle after edge:
  - error: edge 0;
  - SW: edge 1;
  - load: edge 2;
  - SB/SH: edge 3.
- Throughput: one request per (latency + 2) cycles. A new request is accepted at the edge that leaves RESP→IDLE plus one, i.e. `req_ready` is high for at least one cycle between requests.
- Reset mid-operation: `mem_rw` returns to 1 immediately. A WRITE cycle cut by reset before its edge performs no write. No `resp_valid` is issued for the aborted request.
- `resp_rdata`/`resp_err` hold their values until the next RESP; only `resp_valid` qualifies them.

## Test plan
- Store word: SW addr 0x10, wdata 0xDEADBEEF → exactly one cycle with `mem_rw` 0, `mem_addr` 4, `mem_wdata` 0xDEADBEEF. `resp_valid` in the cycle after edge 1, err 0.
- Loads from that word:
  - LB 0x13 → 0xFFFFFFDE;
  - LBU 0x13 → 0x000000DE;
  - LH 0x12 → 0xFFFFDEAD;
  - LHU 0x10 → 0x0000BEEF;
  - LW 0x10 → 0xDEADBEEF.
  - Each `resp_valid` is in the cycle after edge 2.
- Sub-word stores:
  - SB 0x11, wdata 0x000000AA → READ then one write of 0xDEADAAEF to word 4.
  - Then SH 0x12, wdata 0x00001234 → word becomes 0x1234AAEF. LW 0x10 confirms.
- Errors:
  - LW 0x02, SH 0x11, load funct3 011 → `resp_err` 1, `resp_rdata` 0, response after edge 0.
  - `mem_rw` stays 1 throughout; word 0 is unchanged.
- Back-to-back: `req_valid` held high with 3 queued SWs → `req_ready` low from accept through RESP. Each request is accepted once, 3 writes and 3 responses in order, no duplicate.
- Reset in WRITE: assert `rst_n` low during the SB write cycle → `mem_rw` 1 immediately, target word unchanged, no `resp_valid`, all outputs at reset values. The next SW after release completes normally.
